ppt_pulse_controller: RTL



---
 rtl/ppt_pulse_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ppt_pulse_controller.sv
// PPT trigger pulse-train generator on a prescaled tick of 2^(clk_div+1) clk cycles; start latency 1 clk, all outputs registered.
// Optional PPT_CONTINUOUS_EN: count==0 becomes an unlimited train (count_done wraps) that only run_ppt low can end.
module ppt_pulse_controller #(
    parameter int PRESC_W = 32,
    parameter int PER_W   = 14,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       clk_div,
    input  logic [PER_W-1:0] period,
    input  logic [PER_W-1:0] width,
    input  logic [CNT_W-1:0] count,
    input  logic             run_ppt,
    output logic             ppt_out,
    output logic [CNT_W-1:0] count_done,
    output logic             done,
    output logic             cfg_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
    localparam logic [PER_W-1:0]   PER_ONE   = PER_W'(1);
    localparam logic [PER_W-1:0]   PER_TWO   = PER_W'(2);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PER_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_done_q, cnt_done_d;
    logic               cfg_err_q, cfg_err_d;
    logic [4:0]         div_q, div_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [PER_W-1:0]   wid_q, wid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ppt_out_q, done_q, busy_q;

    logic [PRESC_W-1:0] presc_lim;
    logic               tick;
    logic               cfg_ok;
    logic               unlimited;

    // At clk_div=31 the shift yields 0 and the subtraction wraps to all ones (2^32-1).
    assign presc_lim = (PRESC_ONE << ({1'b0, div_q} + 6'd1)) - PRESC_ONE;
    assign tick      = (presc_q == presc_lim);

    always_comb begin
        cfg_ok = (period >= PER_TWO) && (width != '0) && (width < period);
`ifndef PPT_CONTINUOUS_EN
        cfg_ok = cfg_ok && (count != '0);
`endif
    end

`ifdef PPT_CONTINUOUS_EN
    assign unlimited = (cnt_q == '0);
`else
    assign unlimited = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        phase_d    = phase_q;
        cnt_done_d = cnt_done_q;
        cfg_err_d  = cfg_err_q;
        div_d      = div_q;
        per_d      = per_q;
        wid_d      = wid_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (run_ppt) begin
                    div_d      = clk_div;
                    per_d      = period;
                    wid_d      = width;
                    cnt_d      = count;
                    cnt_done_d = '0;
                    presc_d    = '0;
                    phase_d    = '0;
                    cfg_err_d  = !cfg_ok;
                    state_d    = cfg_ok ? S_PULSE : S_DONE;
                end
            end
            S_PULSE, S_GAP: begin
                if (!run_ppt) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    presc_d = '0;
                    // End of period wins over end of pulse width.
                    if (phase_q == per_q - PER_ONE) begin
                        phase_d    = '0;
                        cnt_done_d = cnt_done_q + CNT_ONE;
                        state_d    = (cnt_done_d == cnt_q && !unlimited) ? S_DONE : S_PULSE;
                    end else begin
                        phase_d = phase_q + PER_ONE;
                        if (state_q == S_PULSE && phase_q == wid_q - PER_ONE) begin
                            state_d = S_GAP;
                        end
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            S_DONE: begin
                if (!run_ppt) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            phase_q    <= '0;
            cnt_done_q <= '0;
            cfg_err_q  <= 1'b0;
            div_q      <= '0;
            per_q      <= '0;
            wid_q      <= '0;
            cnt_q      <= '0;
            ppt_out_q  <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            phase_q    <= phase_d;
            cnt_done_q <= cnt_done_d;
            cfg_err_q  <= cfg_err_d;
            div_q      <= div_d;
            per_q      <= per_d;
            wid_q      <= wid_d;
            cnt_q      <= cnt_d;
            ppt_out_q  <= (state_d == S_PULSE);
            done_q     <= (state_d == S_DONE);
            busy_q     <= (state_d == S_PULSE) || (state_d == S_GAP);
        end
    end

    assign ppt_out    = ppt_out_q;
    assign count_done = cnt_done_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign busy       = busy_q;

endmodule
